bound_left_right_add: RTL and testbench
=======================================

// Module: bound_left_right_add
// PURPOSE
//   Pads every active row of a video stream with P = KSZ/2 extra pixels on the left and right.
//   Each IW-pixel row becomes IW+2P pixels wide, so a KSZ x KSZ kernel has valid columns at the image edges.
//   Sits directly upstream of bound_up_down_add and feeds it. Its output rows are the ones that stage pads vertically.
//   Stream format: din_vsync/din_hsync level-valid strobes; din is valid while din_hsync=1.
// PARAMETERS
//   KSZ      5   kernel edge length (3/5/7); P = KSZ/2 = pad width per side
//   DW       8   pixel data width
//   PAD_MODE 1   0 = constant pad (PAD_VAL); 1 = replicate the edge pixel
//   PAD_VAL  0   pad value used when PAD_MODE=0, DW bits
// PORTS
//   clk         in   1    system clock; single clock domain
//   rst         in   1    synchronous, active-high reset
//   din_vsync   in   1    input frame-valid
//   din_hsync   in   1    input line-valid
//   din         in   DW   input pixel, qualified by din_hsync
//   dout_vsync  out  1    output frame-valid
//   dout_hsync  out  1    output line-valid; high for (input row length + 2P) cycles
//   dout        out  DW   output pixel, qualified by dout_hsync; 0 whenever dout_hsync=0
//   err_hblank  out  1    sticky flag: a new row started before the right pad finished
// BEHAVIOUR
// - Reset (rst=1 at a clk edge) takes effect on the next edge:
//     dout_vsync=0, dout_hsync=0, dout=0, err_hblank=0.
//     FSM returns to IDLE and the delay line is flushed to 0.
//     Reset mid-row aborts the row, with no partial output afterwards.
// - Timing: let din_hsync rise at cycle t with pixel p0, and stay high for L cycles (nominally L=IW).
//     dout_hsync is high for cycles t+1 .. t+L+2P, all registered.
//     Cycles t+1..t+P: left pad, equal to p0 (PAD_MODE=1) or PAD_VAL (PAD_MODE=0).
//     Cycles t+P+1 .. t+P+L: input pixel i appears at t+P+1+i, so data latency is P+1.
//     Cycles t+P+L+1 .. t+L+2P: right pad, equal to the last pixel p(L-1) or PAD_VAL.
// - Row length follows din_hsync, not a counter. Rows of any length L>=1 are handled.
//     L=1 gives P copies of p0, then p0, then P copies of p0.
// - dout_vsync = din_vsync delayed by exactly 1 cycle, so it is rise-aligned with dout_hsync.
//     Upstream guarantees a horizontal blanking of at least 2P cycles.
//     Upstream guarantees at least 2P+1 cycles from the last din_hsync fall to the din_vsync fall.
// - FSM states and transitions:
//     IDLE : on din_hsync rising, capture p0 and go to LEFT.
//     LEFT : count P cycles, then go to BODY.
//     BODY : stream delayed pixels. When the delayed hsync falls, latch the last pixel and go to RIGHT.
//     RIGHT: count P cycles, then go to IDLE.
// - Simultaneous events:
//     din_hsync rising while in RIGHT: the right pad is truncated and err_hblank is set (sticky until rst).
//       The new row's LEFT starts on the next cycle with no gap.
//       dout_hsync stays high across the boundary.
//     din_vsync falling mid-row: the row still completes. vsync is a pure delay and does not gate hsync/data.
// - Counters are sized $clog2(P+1) bits. They saturate/wrap only within LEFT/RIGHT.
// - No backpressure. The block accepts a pixel every cycle din_hsync=1.
// STRUCTURE
//   Shared package bound_pkg, also used by bound_up_down_add:
//     PAD_ZERO=0, PAD_REPL=1 constants
//     function pad_w(ksz) = ksz/2
//     FSM state encoding for IDLE/LEFT/BODY/RIGHT
//   Sub-module pix_delay_line #(DW, DEPTH=P+1): shift register carrying {hsync, data}, with sync reset.
//   Top level holds the FSM, the pad counters, the p0/last-pixel capture registers, and the vsync delay register.
// TESTING  (KSZ=5 so P=2, DW=8, single frame unless noted)
//   1. PAD_MODE=1, row 20,18,32,11 with hblank 4.
//      -> dout = 20,20,20,18,32,11,11,11 with dout_hsync high for 8 cycles, starting 1 cycle after din_hsync rises.
//   2. PAD_MODE=0, PAD_VAL=0, rows 20,18,32,11 then 51,33,67,2.
//      -> 0,0,20,18,32,11,0,0 then 0,0,51,33,67,2,0,0. Zero between rows.
//   3. Single-pixel row 77 (L=1), PAD_MODE=1.
//      -> 77 x5, dout_hsync high for exactly 5 cycles.
//   4. Blanking of 2 cycles (a violation).
//      -> the first row's right pad shows 1 pixel, the second row starts seamlessly, and err_hblank=1 until rst.
//   5. rst asserted at the 3rd output pixel of a row.
//      -> the next cycle shows all outputs 0. After release, the next frame is output correctly (as in case 1).
//   6. Two frames with 30-cycle vertical blanking.
//      -> dout_vsync equals din_vsync delayed by 1, identical output for both frames, and no residue from frame 1.

Source files
------------

// File: rtl/bound_pkg.sv
// Shared definitions for the horizontal and vertical border-padding stages.
package bound_pkg;

   localparam int PAD_ZERO = 0;
   localparam int PAD_REPL = 1;

   // Pad width on each side of a KSZ x KSZ kernel.
   function automatic int pad_w(input int ksz);
      return ksz / 2;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LEFT  = 2'd1,
      ST_BODY  = 2'd2,
      ST_RIGHT = 2'd3
   } state_t;

endpackage

// File: rtl/pix_delay_line.sv
// Fixed-depth shift register for {hsync, pixel}. Also exposes the hsync one
// stage before the output so the controller can see a row edge a cycle early.
module pix_delay_line #(
   parameter int DW    = 8,
   parameter int DEPTH = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_hs,
   input  logic [DW-1:0] i_data,
   output logic          o_hs,
   output logic          o_hs_pre,
   output logic [DW-1:0] o_data
);

   logic [DEPTH-1:0]         r_hs;
   logic [DEPTH-1:0][DW-1:0] r_data;

   // Shift every cycle; reset flushes the whole line to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hs   <= '0;
         r_data <= '0;
      end else begin
         r_hs   <= {r_hs[DEPTH-2:0], i_hs};
         r_data <= {r_data[DEPTH-2:0], i_data};
      end
   end

   assign o_hs     = r_hs[DEPTH-1];
   assign o_hs_pre = r_hs[DEPTH-2];
   assign o_data   = r_data[DEPTH-1];

endmodule

// File: rtl/bound_left_right_add.sv
// Adds P = KSZ/2 pad pixels to the left and right of every active row.
//
//   state | meaning
//   IDLE  | no row in flight, outputs quiet
//   LEFT  | emitting left pad (first pixel or PAD_VAL)
//   BODY  | passing delayed row pixels through
//   RIGHT | emitting right pad (last pixel or PAD_VAL), P cycles
module bound_left_right_add
   import bound_pkg::*;
#(
   parameter int            KSZ      = 5,
   parameter int            DW       = 8,
   parameter int            PAD_MODE = 1,
   parameter logic [DW-1:0] PAD_VAL  = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din_vsync,
   input  logic          din_hsync,
   input  logic [DW-1:0] din,
   output logic          dout_vsync,
   output logic          dout_hsync,
   output logic [DW-1:0] dout,
   output logic          err_hblank
);

   localparam int            P        = pad_w(KSZ);
   localparam int            CW       = $clog2(P + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(P - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_hs_prev;
   logic          r_pend;
   logic [DW-1:0] r_p0;
   logic [DW-1:0] r_last;
   logic          r_err;
   logic          r_vs;

   logic          w_rise;
   logic          w_start;
   logic          w_go_left;
   logic          w_err_set;
   logic          w_dl_hs;
   logic          w_dl_hs_pre;
   logic [DW-1:0] w_dl_data;

   pix_delay_line #(
      .DW    (DW),
      .DEPTH (P + 1)
   ) u_dl (
      .clk      (clk),
      .rst      (rst),
      .i_hs     (din_hsync),
      .i_data   (din),
      .o_hs     (w_dl_hs),
      .o_hs_pre (w_dl_hs_pre),
      .o_data   (w_dl_data)
   );

   // A row that rises before its predecessor's right pad is done is held
   // in r_pend until the FSM can take it from RIGHT.
   assign w_rise    = din_hsync & ~r_hs_prev;
   assign w_start   = w_rise | r_pend;
   assign w_go_left = (w_state_nxt == ST_LEFT) && (r_state != ST_LEFT);
   assign w_err_set = w_rise && (r_state != ST_IDLE) &&
                      !((r_state == ST_RIGHT) && (r_cnt == '0));

   // Next-state logic. LEFT->BODY and BODY->RIGHT follow the delay line's
   // early hsync tap, so pixel alignment holds even for truncated pads.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_start) w_state_nxt = ST_LEFT;
         end
         ST_LEFT: begin
            if (w_dl_hs_pre) w_state_nxt = ST_BODY;
         end
         ST_BODY: begin
            if (!w_dl_hs_pre) begin
               w_state_nxt = ST_RIGHT;
               w_cnt_nxt   = CNT_LOAD;
            end
         end
         ST_RIGHT: begin
            if (w_start)            w_state_nxt = ST_LEFT;
            else if (r_cnt == '0)   w_state_nxt = ST_IDLE;
            else                    w_cnt_nxt   = r_cnt - CW'(1);
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State, counter, capture registers and the vsync delay.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         // Treat hsync as already high so a row cut by reset is not
         // mistaken for a fresh row once reset releases.
         r_hs_prev <= 1'b1;
         r_pend    <= 1'b0;
         r_p0      <= '0;
         r_last    <= '0;
         r_err     <= 1'b0;
         r_vs      <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_hs_prev <= din_hsync;
         r_pend    <= (r_pend | w_rise) & ~w_go_left;
         r_vs      <= din_vsync;
         if (w_rise) r_p0 <= din;
         if ((r_state == ST_BODY) && !w_dl_hs_pre) r_last <= w_dl_data;
         if (w_err_set) r_err <= 1'b1;
      end
   end

   // Output select from registered sources; data forced to 0 outside a row.
   always_comb begin
      dout = '0;
      case (r_state)
         ST_LEFT:  dout = (PAD_MODE == PAD_REPL) ? r_p0 : PAD_VAL;
         ST_BODY:  dout = w_dl_hs ? w_dl_data : '0;
         ST_RIGHT: dout = (PAD_MODE == PAD_REPL) ? r_last : PAD_VAL;
         default:  dout = '0;
      endcase
   end

   assign dout_hsync = (r_state != ST_IDLE);
   assign dout_vsync = r_vs;
   assign err_hblank = r_err;

endmodule

// File: tb/tb_bound_left_right_add.sv
// Directed bench: one replicate-mode and one zero-pad instance share stimulus.
module tb_bound_left_right_add;

   typedef struct {
      logic       vs;
      logic       hs;
      logic [7:0] din;
      logic       ehs;
      logic [7:0] er;
      logic [7:0] ez;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       din_vsync;
   logic       din_hsync;
   logic [7:0] din;
   logic       vs_r, hs_r, err_r;
   logic       vs_z, hs_z, err_z;
   logic [7:0] d_r, d_z;

   int n_checks = 0;
   int n_errors = 0;

   vec_t main_tab [29];
   vec_t hb_tab   [19];

   always #5 clk = ~clk;

   bound_left_right_add #(.KSZ(5), .DW(8), .PAD_MODE(1), .PAD_VAL(8'd0)) dut_r (
      .clk(clk), .rst(rst), .din_vsync(din_vsync), .din_hsync(din_hsync), .din(din),
      .dout_vsync(vs_r), .dout_hsync(hs_r), .dout(d_r), .err_hblank(err_r));

   bound_left_right_add #(.KSZ(5), .DW(8), .PAD_MODE(0), .PAD_VAL(8'd0)) dut_z (
      .clk(clk), .rst(rst), .din_vsync(din_vsync), .din_hsync(din_hsync), .din(din),
      .dout_vsync(vs_z), .dout_hsync(hs_z), .dout(d_z), .err_hblank(err_z));

   function automatic vec_t mk(input bit vs, input bit hs, input int d,
                               input bit ehs, input int er, input int ez);
      vec_t v;
      v.vs  = vs;
      v.hs  = hs;
      v.din = 8'(d);
      v.ehs = ehs;
      v.er  = 8'(er);
      v.ez  = 8'(ez);
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input bit vs, input bit hs, input int d);
      din_vsync = vs;
      din_hsync = hs;
      din       = 8'(d);
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v, input string tag);
      step(v.vs, v.hs, int'(v.din));
      chk({tag, " vs_r"}, int'(vs_r), int'(v.vs));
      chk({tag, " vs_z"}, int'(vs_z), int'(v.vs));
      chk({tag, " hs_r"}, int'(hs_r), int'(v.ehs));
      chk({tag, " hs_z"}, int'(hs_z), int'(v.ehs));
      chk({tag, " d_r"},  int'(d_r),  int'(v.er));
      chk({tag, " d_z"},  int'(d_z),  int'(v.ez));
   endtask

   task automatic quiet(input string tag);
      chk({tag, " hs_r"}, int'(hs_r), 0);
      chk({tag, " hs_z"}, int'(hs_z), 0);
      chk({tag, " d_r"},  int'(d_r),  0);
      chk({tag, " d_z"},  int'(d_z),  0);
   endtask

   initial begin
      // rows 20,18,32,11 / 51,33,67,2 (hblank 6) / single pixel 77
      main_tab[0]  = mk(1,0, 0, 0, 0, 0);
      main_tab[1]  = mk(1,1,20, 1,20, 0);
      main_tab[2]  = mk(1,1,18, 1,20, 0);
      main_tab[3]  = mk(1,1,32, 1,20,20);
      main_tab[4]  = mk(1,1,11, 1,18,18);
      main_tab[5]  = mk(1,0, 0, 1,32,32);
      main_tab[6]  = mk(1,0, 0, 1,11,11);
      main_tab[7]  = mk(1,0, 0, 1,11, 0);
      main_tab[8]  = mk(1,0, 0, 1,11, 0);
      main_tab[9]  = mk(1,0, 0, 0, 0, 0);
      main_tab[10] = mk(1,0, 0, 0, 0, 0);
      main_tab[11] = mk(1,1,51, 1,51, 0);
      main_tab[12] = mk(1,1,33, 1,51, 0);
      main_tab[13] = mk(1,1,67, 1,51,51);
      main_tab[14] = mk(1,1, 2, 1,33,33);
      main_tab[15] = mk(1,0, 0, 1,67,67);
      main_tab[16] = mk(1,0, 0, 1, 2, 2);
      main_tab[17] = mk(1,0, 0, 1, 2, 0);
      main_tab[18] = mk(1,0, 0, 1, 2, 0);
      main_tab[19] = mk(1,0, 0, 0, 0, 0);
      main_tab[20] = mk(1,1,77, 1,77, 0);
      main_tab[21] = mk(1,0, 0, 1,77, 0);
      main_tab[22] = mk(1,0, 0, 1,77,77);
      main_tab[23] = mk(1,0, 0, 1,77, 0);
      main_tab[24] = mk(1,0, 0, 1,77, 0);
      main_tab[25] = mk(1,0, 0, 0, 0, 0);
      main_tab[26] = mk(1,0, 0, 0, 0, 0);
      main_tab[27] = mk(0,0, 0, 0, 0, 0);
      main_tab[28] = mk(0,0, 0, 0, 0, 0);

      // hblank of only 2 cycles: right pad truncated to 1, seamless hsync
      hb_tab[0]  = mk(1,0, 0, 0, 0, 0);
      hb_tab[1]  = mk(1,1,20, 1,20, 0);
      hb_tab[2]  = mk(1,1,18, 1,20, 0);
      hb_tab[3]  = mk(1,1,32, 1,20,20);
      hb_tab[4]  = mk(1,1,11, 1,18,18);
      hb_tab[5]  = mk(1,0, 0, 1,32,32);
      hb_tab[6]  = mk(1,0, 0, 1,11,11);
      hb_tab[7]  = mk(1,1,51, 1,11, 0);
      hb_tab[8]  = mk(1,1,33, 1,51, 0);
      hb_tab[9]  = mk(1,1,67, 1,51,51);
      hb_tab[10] = mk(1,1, 2, 1,33,33);
      hb_tab[11] = mk(1,0, 0, 1,67,67);
      hb_tab[12] = mk(1,0, 0, 1, 2, 2);
      hb_tab[13] = mk(1,0, 0, 1, 2, 0);
      hb_tab[14] = mk(1,0, 0, 1, 2, 0);
      hb_tab[15] = mk(1,0, 0, 0, 0, 0);
      hb_tab[16] = mk(1,0, 0, 0, 0, 0);
      hb_tab[17] = mk(1,0, 0, 0, 0, 0);
      hb_tab[18] = mk(0,0, 0, 0, 0, 0);

      rst = 1'b1;
      din_vsync = 1'b0;
      din_hsync = 1'b0;
      din = '0;
      repeat (3) @(posedge clk);
      #1;
      quiet("reset");
      chk("reset vs_r",  int'(vs_r),  0);
      chk("reset err_r", int'(err_r), 0);
      chk("reset err_z", int'(err_z), 0);
      rst = 1'b0;

      foreach (main_tab[i]) apply(main_tab[i], $sformatf("f1[%0d]", i));
      chk("f1 err_r", int'(err_r), 0);
      chk("f1 err_z", int'(err_z), 0);

      for (int i = 0; i < 30; i++) begin
         step(0, 0, 0);
         quiet($sformatf("vblank[%0d]", i));
         chk($sformatf("vblank[%0d] vs_r", i), int'(vs_r), 0);
      end

      foreach (main_tab[i]) apply(main_tab[i], $sformatf("f2[%0d]", i));

      foreach (hb_tab[i]) apply(hb_tab[i], $sformatf("hb[%0d]", i));
      chk("hb err_r", int'(err_r), 1);
      chk("hb err_z", int'(err_z), 1);
      repeat (10) step(0, 0, 0);
      chk("hb sticky err_r", int'(err_r), 1);
      chk("hb sticky err_z", int'(err_z), 1);

      // reset while the third output pixel of a 6-pixel row is showing
      step(1, 0, 0);
      step(1, 1, 20);
      chk("rs p1 d_r", int'(d_r), 20);
      step(1, 1, 18);
      step(1, 1, 32);
      chk("rs p3 d_r", int'(d_r), 20);
      chk("rs p3 d_z", int'(d_z), 20);
      rst = 1'b1;
      step(1, 1, 11);
      rst = 1'b0;
      quiet("rs after");
      chk("rs after vs_r",  int'(vs_r),  0);
      chk("rs after vs_z",  int'(vs_z),  0);
      chk("rs after err_r", int'(err_r), 0);
      chk("rs after err_z", int'(err_z), 0);
      step(1, 1, 5);
      quiet("rs tail0");
      step(1, 1, 6);
      quiet("rs tail1");
      for (int i = 0; i < 5; i++) begin
         step(1, 0, 0);
         quiet($sformatf("rs tail%0d", i + 2));
      end
      repeat (6) step(0, 0, 0);

      foreach (main_tab[i]) apply(main_tab[i], $sformatf("pr[%0d]", i));
      chk("pr err_r", int'(err_r), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
